video_frame_ctrl: RTL and testbench
===================================

Name: video_frame_ctrl

Overview:
- Frame sequencer that feeds the VGA sync core's pixel stream input.
- Scans pixel coordinates in raster order and requests each pixel from the upstream layer pipeline, which has 1-cycle read latency.
- Packs each returned pixel as {sof, rgb} and drives the valid/ready stream with full backpressure support.
- Configured through the video slot bus: enable, solid-colour bypass, status readback.

Parameters:
CD, 12, colour depth (rgb width)
HMAX, 640, active pixels per line
VMAX, 480, active lines per frame

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous active-low reset
cs  in  1  slot select
write  in  1  write strobe, valid with cs
read  in  1  read strobe, valid with cs
addr  in  14  register address; only addr[1:0] decoded
wr_data  in  32  write data
rd_data  out  32  read data, combinational from addr[1:0]
x  out  10  requested pixel column
y  out  10  requested pixel row
req  out  1  pixel request; src_rgb returns exactly 1 cycle later
src_rgb  in  CD  pixel colour from layer pipeline
so_data  out  CD+1  {sof, rgb}; bit CD = start of frame
so_valid  out  1  stream valid
so_ready  in  1  stream ready (from sync core line buffer)

Behaviour:
- Registers:
  - addr 0 CTRL, RW: bit0 enable, bit1 bypass.
  - addr 1 COLOR, RW: bits[CD-1:0] solid colour.
  - addr 2 STATUS, RO: bit0 busy, bit1 in-frame.
  - addr 3 reads 0.
  - Writes take effect the cycle after cs&write.
- Reset values: all registers 0; x=0, y=0, req=0, so_valid=0, so_data=0; FSM in IDLE; FIFO empty.
- FSM IDLE:
  - Enters RUN when enable=1 and the FIFO is empty.
  - On entry, latches bypass and COLOR into frame-shadow registers. Mid-frame writes never alter the current frame's mode or colour.
- FSM RUN: issues requests.
  - req=1 when (FIFO occupancy + in-flight) < 2.
  - Each request advances x. At x=HMAX-1, x wraps to 0 and y increments.
  - At x=HMAX-1 and y=VMAX-1, both wrap to 0. If enable=1, the FSM stays in RUN and re-latches the shadows. Otherwise it goes to DRAIN.
- FSM DRAIN: stays until the FIFO and the in-flight slot are empty, then goes to IDLE.
- Clearing enable mid-frame does not abort the frame. The full frame completes, then the FSM goes to DRAIN.
- Return path:
  - The cycle after req, the returned pixel is pushed into a 2-entry FIFO.
  - Pushed rgb is src_rgb, or shadow COLOR when bypass is set.
  - Pushed sof = 1 if the request coordinate was (0,0).
  - The FIFO head drives so_data/so_valid. Pop on so_valid&so_ready.
- Latency: first so_valid asserts 2 cycles after the IDLE->RUN transition.
- Throughput: 1 pixel/cycle with so_ready held high.
- Backpressure:
  - so_data stays stable while so_valid=1 and so_ready=0.
  - The credit rule guarantees the FIFO never overflows: a push with a full FIFO is impossible by construction. The bench asserts this.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- busy = state != IDLE. in-frame = RUN and (x,y) != (0,0).
- Async reset mid-frame clears everything immediately. The next frame restarts at (0,0) with sof.

Optional Feature:
- Macro: VIDEO_FRAME_CNT_EN.
- Defined: adds a 16-bit wrapping counter that increments each time the sof pixel is popped. It reads at STATUS[31:16]. A write to addr 2 with wr_data[31]=1 clears it.
- Undefined: STATUS[31:16] read 0 and writes to addr 2 are ignored.

Decomposition:
- Package video_pkg holds:
  - typedef ctrl_state_t {IDLE, RUN, DRAIN}
  - register address localparams CTRL_ADDR, COLOR_ADDR, STATUS_ADDR
  - localparam SOF_BIT = CD
- Sub-module pix_fifo2: parameterised 2-entry FIFO (width CD+1) with full/empty/count outputs.

Test Plan:
- Write CTRL=1, src_rgb = x[3:0]-derived, so_ready=1 -> 307200 beats; only beat 0 has so_data[12]=1; beat 641 rgb matches (x=1,y=1); no bubbles after the first valid.
- CTRL=3, COLOR=12'hF00 -> every beat rgb=12'hF00 regardless of src_rgb; write COLOR=12'h0F0 mid-frame -> change appears only at the next sof.
- so_ready toggles pseudo-randomly at 50% -> pixel order intact, so_data stable while stalled, FIFO-overflow assertion never fires.
- Clear enable at pixel 1000 -> frame completes all 307200 beats, busy drops within 3 cycles of the last pop, no further sof.
- Assert reset_n=0 at pixel 5000, release, re-enable -> outputs 0 during reset; first post-reset beat has sof=1 at (0,0).
- With VIDEO_FRAME_CNT_EN, run 3 frames -> STATUS[31:16]=3; write addr2 wr_data=32'h8000_0000 -> reads 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video frame sequencer.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] CTRL_ADDR   = 2'd0;
  localparam logic [1:0] COLOR_ADDR  = 2'd1;
  localparam logic [1:0] STATUS_ADDR = 2'd2;

  localparam int DEFAULT_CD = 12;
  localparam int SOF_BIT    = DEFAULT_CD;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry pixel FIFO; head is always presented on dout.
module pix_fifo2 #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  // Push into a full FIFO is only legal alongside a pop: the slot written is the head being retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/video_frame_ctrl.sv
// Raster-order frame sequencer feeding the VGA sync core pixel stream.
// Optional sof-pop frame counter at STATUS[31:16] enabled by VIDEO_FRAME_CNT_EN.
module video_frame_ctrl
  import video_pkg::*;
#(
  parameter int CD   = DEFAULT_CD,
  parameter int HMAX = 640,
  parameter int VMAX = 480
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          req,
  input  logic [CD-1:0] src_rgb,
  output logic [CD:0]   so_data,
  output logic          so_valid,
  input  logic          so_ready
);

  ctrl_state_t   state, next_state;
  logic [1:0]    ctrl_q;
  logic [CD-1:0] color_q;
  logic          shadow_bypass;
  logic [CD-1:0] shadow_color;
  logic          latch_shadow;
  logic          req_q;
  logic          pix_sof_q;
  logic          pix_byp_q;
  logic [CD-1:0] pix_color_q;
  logic          fifo_full, fifo_empty, pop;
  logic [1:0]    fifo_count;
  logic [2:0]    pending;
  logic [CD:0]   push_data;
  logic          wr_en, last_px, busy, in_frame;
  logic [15:0]   frame_cnt;

  assign wr_en   = cs & write;
  assign last_px = (x == 10'(HMAX - 1)) && (y == 10'(VMAX - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= 2'b00;
      color_q <= '0;
    end else if (wr_en) begin
      if (addr[1:0] == CTRL_ADDR)  ctrl_q  <= wr_data[1:0];
      if (addr[1:0] == COLOR_ADDR) color_q <= wr_data[CD-1:0];
    end
  end

  // Credit: pixels held plus the one in flight, less the one leaving this cycle, must stay below 2.
  assign pop     = so_valid & so_ready;
  assign pending = {1'b0, fifo_count} + {2'b00, req_q} - {2'b00, pop};
  assign req     = (state == RUN) && (pending < 3'd2);

  always_comb begin
    next_state   = state;
    latch_shadow = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_q[0] && fifo_empty) begin
          next_state   = RUN;
          latch_shadow = 1'b1;
        end
      end
      RUN: begin
        if (req && last_px) begin
          if (ctrl_q[0]) latch_shadow = 1'b1;
          else           next_state   = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !req_q) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      shadow_bypass <= 1'b0;
      shadow_color  <= '0;
      x             <= 10'd0;
      y             <= 10'd0;
      req_q         <= 1'b0;
      pix_sof_q     <= 1'b0;
      pix_byp_q     <= 1'b0;
      pix_color_q   <= '0;
    end else begin
      state <= next_state;
      req_q <= req;
      if (latch_shadow) begin
        shadow_bypass <= ctrl_q[1];
        shadow_color  <= color_q;
      end
      // Mode travels with each request so a shadow re-latch at frame wrap cannot touch the last pixel.
      if (req) begin
        pix_sof_q   <= (x == 10'd0) && (y == 10'd0);
        pix_byp_q   <= shadow_bypass;
        pix_color_q <= shadow_color;
        if (x == 10'(HMAX - 1)) begin
          x <= 10'd0;
          y <= (y == 10'(VMAX - 1)) ? 10'd0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  assign push_data = {pix_sof_q, pix_byp_q ? pix_color_q : src_rgb};

  pix_fifo2 #(.W(CD + 1)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_q),
    .pop     (pop),
    .din     (push_data),
    .dout    (so_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign so_valid = ~fifo_empty;
  assign busy     = (state != IDLE);
  assign in_frame = (state == RUN) && ((x != 10'd0) || (y != 10'd0));

`ifdef VIDEO_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 16'd0;
    end else if (wr_en && (addr[1:0] == STATUS_ADDR) && wr_data[31]) begin
      frame_cnt <= 16'd0;
    end else if (pop && so_data[CD]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = 16'd0;
`endif

  always_comb begin
    rd_data = '0;
    case (addr[1:0])
      CTRL_ADDR:   rd_data[1:0]    = ctrl_q;
      COLOR_ADDR:  rd_data[CD-1:0] = color_q;
      STATUS_ADDR: rd_data         = {frame_cnt, 14'd0, in_frame, busy};
      default:     rd_data         = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, read, addr[13:2], wr_data[31:CD], fifo_full};

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Directed bench for video_frame_ctrl on a small 8x4 raster.
module tb_video_frame_ctrl;

  localparam int CD   = 12;
  localparam int HMAX = 8;
  localparam int VMAX = 4;
  localparam int NPIX = HMAX * VMAX;

  logic          clk;
  logic          reset_n;
  logic          cs, write, read;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [9:0]    x, y;
  logic          req;
  logic [CD-1:0] src_rgb;
  logic [CD:0]   so_data;
  logic          so_valid;
  logic          so_ready;

  video_frame_ctrl #(.CD(CD), .HMAX(HMAX), .VMAX(VMAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .write    (write),
    .read     (read),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .x        (x),
    .y        (y),
    .req      (req),
    .src_rgb  (src_rgb),
    .so_data  (so_data),
    .so_valid (so_valid),
    .so_ready (so_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          pop_cnt = 0;
  int          ovf_cnt = 0;
  bit          rand_ready = 0;
  logic [CD:0] exp_q[$];

  function automatic logic [CD-1:0] pix_f(input logic [9:0] px, input logic [9:0] py);
    return {py[3:0], px[3:0], 4'h5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream layer pipeline: one-cycle read latency.
  initial src_rgb = '0;
  always @(posedge clk) if (req) src_rgb <= pix_f(x, y);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) so_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [CD:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'({so_valid, so_data}), 32'({1'b1, prev_data}));
      if (so_valid && so_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected no beat at %0t", so_data, $time);
        end else begin
          chk("beat", 32'(so_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = so_valid && !so_ready;
      prev_data  = so_data;
      if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) ovf_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic [13:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [13:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pops_reached", 32'(pop_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] d;
    int n = 0;
    do begin
      reg_read(14'd2, d);
      n++;
    end while (d[0] && n < budget);
    chk("drain_idle", 32'(d[0]), 32'd0);
  endtask

  task automatic build_frame(input logic byp, input logic [CD-1:0] color);
    for (int yy = 0; yy < VMAX; yy++)
      for (int xx = 0; xx < HMAX; xx++)
        exp_q.push_back({(xx == 0 && yy == 0), byp ? color : pix_f(10'(xx), 10'(yy))});
  endtask

  // ---------------- register vectors ----------------
  typedef struct {
    bit          do_wr;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [13:0] raddr;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  reg_vec_t vecs[9];

  initial begin
    logic [31:0] d;
    int n, popped, bubbles, guard;

    vecs[0] = '{1'b0, 14'd0, 32'h0,         14'd0, 32'h0,   "ctrl_rst"};
    vecs[1] = '{1'b0, 14'd0, 32'h0,         14'd1, 32'h0,   "color_rst"};
    vecs[2] = '{1'b0, 14'd0, 32'h0,         14'd2, 32'h0,   "status_rst"};
    vecs[3] = '{1'b1, 14'd0, 32'hFFFF_FFFE, 14'd0, 32'h2,   "ctrl_bypass"};
    vecs[4] = '{1'b1, 14'd1, 32'hFFFF_FABC, 14'd1, 32'hABC, "color_mask"};
    vecs[5] = '{1'b0, 14'd0, 32'h0,         14'd3, 32'h0,   "addr3_zero"};
    vecs[6] = '{1'b1, 14'd4, 32'h0,         14'd0, 32'h0,   "ctrl_alias"};
    vecs[7] = '{1'b1, 14'd2, 32'h3,         14'd2, 32'h0,   "status_ro"};
    vecs[8] = '{1'b1, 14'd1, 32'h0,         14'd5, 32'h0,   "color_alias"};

    reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; wr_data = '0; so_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(so_valid), 32'd0);
    chk("rst_data", 32'(so_data), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) reg_write(vecs[i].waddr, vecs[i].wdata);
      reg_read(vecs[i].raddr, d);
      chk(vecs[i].name, d, vecs[i].exp);
    end

    // Normal mode: latency, gap-free streaming, enable cleared mid-frame 2.
    so_ready = 1'b1;
    pop_cnt = 0;
    build_frame(1'b0, '0);
    build_frame(1'b0, '0);
    reg_write(14'd0, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!so_valid && n < 8);
    chk("first_valid_lat", n, 32'd4);
    popped = 1; bubbles = 0; guard = 0;
    while (popped < 2 * NPIX && guard < 400) begin
      @(negedge clk);
      guard++;
      if (popped == NPIX + 10) begin
        cs = 1'b1; write = 1'b1; addr = 14'd0; wr_data = 32'd0;
      end else begin
        cs = 1'b0; write = 1'b0;
      end
      if (so_valid) popped++;
      else bubbles++;
    end
    cs = 1'b0; write = 1'b0;
    chk("no_bubbles", bubbles, 32'd0);
    chk("frame_beats", popped, 2 * NPIX);
    n = 0;
    do begin
      @(negedge clk);
      addr = 14'd2;
      #1;
      n++;
    end while (rd_data[0] && n < 6);
    chk("busy_drop", 32'(n <= 3), 32'd1);
    repeat (20) @(negedge clk);
    chk("a_pop_total", pop_cnt, 2 * NPIX);
    chk("a_queue_empty", exp_q.size(), 32'd0);

    // Bypass: solid colour, mid-frame COLOR write lands at next sof.
    pop_cnt = 0;
    build_frame(1'b1, 12'hF00);
    build_frame(1'b1, 12'h0F0);
    reg_write(14'd1, 32'h0000_0F00);
    reg_write(14'd0, 32'd3);
    repeat (3) @(negedge clk);
    addr = 14'd2;
    #1;
    chk("status_run", 32'(rd_data[1:0]), 32'd3);
    wait_pops(NPIX / 2, 200);
    reg_write(14'd1, 32'h0000_00F0);
    wait_pops(NPIX + 5, 200);
    reg_write(14'd0, 32'd0);
    wait_pops(2 * NPIX, 200);
    wait_idle(20);
    repeat (10) @(negedge clk);
    chk("b_queue_empty", exp_q.size(), 32'd0);

    // Random backpressure.
    pop_cnt = 0;
    build_frame(1'b0, '0);
    build_frame(1'b0, '0);
    rand_ready = 1;
    reg_write(14'd0, 32'd1);
    wait_pops(NPIX + 5, 600);
    reg_write(14'd0, 32'd0);
    wait_pops(2 * NPIX, 600);
    rand_ready = 0;
    @(negedge clk);
    so_ready = 1'b1;
    wait_idle(20);
    repeat (10) @(negedge clk);
    chk("c_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset mid-frame, then a fresh frame from (0,0).
    pop_cnt = 0;
    build_frame(1'b0, '0);
    reg_write(14'd0, 32'd1);
    wait_pops(10, 100);
    #2;
    reset_n = 1'b0;
    #1;
    addr = 14'd0;
    #1;
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_valid", 32'(so_valid), 32'd0);
    chk("mid_rst_data", 32'(so_data), 32'd0);
    chk("mid_rst_ctrl", rd_data, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pop_cnt = 0;
    build_frame(1'b0, '0);
    reg_write(14'd0, 32'd1);
    wait_pops(3, 50);
    reg_write(14'd0, 32'd0);
    wait_pops(NPIX, 200);
    wait_idle(20);
    repeat (10) @(negedge clk);
    chk("d_queue_empty", exp_q.size(), 32'd0);

    // Frame counter over three frames, then clear.
    reg_write(14'd2, 32'h8000_0000);
    pop_cnt = 0;
    build_frame(1'b0, '0);
    build_frame(1'b0, '0);
    build_frame(1'b0, '0);
    reg_write(14'd0, 32'd1);
    wait_pops(2 * NPIX + 5, 400);
    reg_write(14'd0, 32'd0);
    wait_pops(3 * NPIX, 400);
    wait_idle(20);
    reg_read(14'd2, d);
`ifdef VIDEO_FRAME_CNT_EN
    chk("frame_cnt", d, 32'h0003_0000);
`else
    chk("frame_cnt", d, 32'h0000_0000);
`endif
    reg_write(14'd2, 32'h8000_0000);
    reg_read(14'd2, d);
    chk("frame_cnt_clr", d, 32'd0);
    chk("e_queue_empty", exp_q.size(), 32'd0);

    chk("fifo_overflow", ovf_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
